// File: rtl/i2c_ptr_writer.sv
// I2C register-pointer write engine: address byte plus 0..PTR_BYTES pointer bytes, MSB first.
// Define I2C_PTR_POLL_EN to retry NACKed address bytes (ACK polling) up to POLL_LIMIT times.
module i2c_ptr_writer #(
  parameter int PTR_BYTES    = 2,
  parameter int POLL_LIMIT   = 255,
  parameter int SETTLE_TICKS = 3
) (
  input  logic                   PT_CK,
  input  logic                   RESET,
  input  logic                   GO,
  input  logic [6:0]             SLAVE_ADDRESS,
  input  logic [8*PTR_BYTES-1:0] POINTER,
  input  logic [2:0]             PTR_LEN,
  input  logic                   SDAI,
  output logic                   SDAO,
  output logic                   SCLO,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ACK_OK,
  output logic                   NACK_ERR,
  output logic [7:0]             POLL_CNT
);

  localparam int         PW  = 8 * PTR_BYTES;
  localparam logic [2:0] PB3 = 3'(PTR_BYTES);

  if (PTR_BYTES < 1 || PTR_BYTES > 4 || POLL_LIMIT < 1 || POLL_LIMIT > 255 || SETTLE_TICKS < 1)
  begin : g_param_check
    $error("i2c_ptr_writer: parameter out of legal range");
  end

  typedef enum logic [3:0] {
    IDLE, ARM, START_A, START_B, BIT_SET, BIT_HI, BIT_LO, STOP_A, STOP_B, STOP_C
`ifdef I2C_PTR_POLL_EN
    , SETTLE
`endif
  } state_t;

  typedef enum logic [1:0] {END_OK, END_NACK, END_RETRY} end_t;

  state_t        state;
  end_t          end_kind;
  logic          rearm;
  logic [6:0]    addr;
  logic [PW-1:0] ptr_sh;
  logic [2:0]    len_q;
  logic [2:0]    bytes_left;
  logic [7:0]    tx_byte;
  logic [3:0]    bit_cnt;
  logic          ack_smp;
`ifdef I2C_PTR_POLL_EN
  localparam logic [7:0] POLL_LIM8   = 8'(POLL_LIMIT);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_TICKS - 1);
  logic       addr_phase;
  logic [7:0] settle_cnt;
`endif

  logic [2:0] len_c;
  logic [5:0] shamt;
  assign len_c = (PTR_LEN > PB3) ? PB3 : PTR_LEN;
  // Left-align the active pointer bytes so each pointer byte is always taken from the top.
  assign shamt = {PB3 - len_c, 3'b000};

  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      end_kind   <= END_OK;
      rearm      <= 1'b1;
      addr       <= '0;
      ptr_sh     <= '0;
      len_q      <= '0;
      bytes_left <= '0;
      tx_byte    <= '0;
      bit_cnt    <= '0;
      ack_smp    <= 1'b0;
      SDAO       <= 1'b1;
      SCLO       <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ACK_OK     <= 1'b0;
      NACK_ERR   <= 1'b0;
      POLL_CNT   <= '0;
`ifdef I2C_PTR_POLL_EN
      addr_phase <= 1'b1;
      settle_cnt <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          SDAO <= 1'b1;
          SCLO <= 1'b1;
          if (!GO) begin
            rearm <= 1'b1;
          end else if (rearm) begin
            rearm    <= 1'b0;
            addr     <= SLAVE_ADDRESS;
            ptr_sh   <= POINTER << shamt;
            len_q    <= len_c;
            ACK_OK   <= 1'b0;
            NACK_ERR <= 1'b0;
            POLL_CNT <= '0;
            BUSY     <= 1'b1;
            state    <= ARM;
          end
        end
        ARM: begin
          SDAO       <= 1'b0;
          SCLO       <= 1'b1;
          tx_byte    <= {addr, 1'b0};
          bytes_left <= len_q;
          bit_cnt    <= '0;
`ifdef I2C_PTR_POLL_EN
          addr_phase <= 1'b1;
`endif
          state      <= START_A;
        end
        START_A: begin
          SDAO  <= 1'b0;
          SCLO  <= 1'b0;
          state <= START_B;
        end
        START_B: begin
          SDAO  <= tx_byte[7];
          SCLO  <= 1'b0;
          state <= BIT_SET;
        end
        BIT_SET: begin
          SCLO  <= 1'b1;
          state <= BIT_HI;
        end
        BIT_HI: begin
          SCLO  <= 1'b0;
          if (bit_cnt == 4'd8) ack_smp <= ~SDAI;
          state <= BIT_LO;
        end
        BIT_LO: begin
          SCLO <= 1'b0;
          if (bit_cnt != 4'd8) begin
            // Bit 9 releases SDA so the slave can drive the ACK.
            SDAO    <= (bit_cnt == 4'd7) ? 1'b1 : tx_byte[6];
            tx_byte <= tx_byte << 1;
            bit_cnt <= bit_cnt + 4'd1;
            state   <= BIT_SET;
          end else if (ack_smp && bytes_left != 3'd0) begin
            SDAO       <= ptr_sh[PW-1];
            tx_byte    <= ptr_sh[PW-1 -: 8];
            ptr_sh     <= ptr_sh << 8;
            bytes_left <= bytes_left - 3'd1;
            bit_cnt    <= '0;
`ifdef I2C_PTR_POLL_EN
            addr_phase <= 1'b0;
`endif
            state      <= BIT_SET;
          end else begin
            SDAO  <= 1'b0;
            state <= STOP_A;
            if (ack_smp) begin
              end_kind <= END_OK;
            end
`ifdef I2C_PTR_POLL_EN
            else if (addr_phase && POLL_CNT != POLL_LIM8) begin
              end_kind <= END_RETRY;
              POLL_CNT <= POLL_CNT + 8'd1;
            end
`endif
            else begin
              end_kind <= END_NACK;
            end
          end
        end
        STOP_A: begin
          SDAO  <= 1'b0;
          SCLO  <= 1'b1;
          state <= STOP_B;
        end
        STOP_B: begin
          SDAO  <= 1'b1;
          SCLO  <= 1'b1;
          state <= STOP_C;
          if (end_kind != END_RETRY) begin
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
            ACK_OK   <= (end_kind == END_OK);
            NACK_ERR <= (end_kind == END_NACK);
          end
        end
        STOP_C: begin
`ifdef I2C_PTR_POLL_EN
          if (end_kind == END_RETRY) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else
`endif
          state <= IDLE;
        end
`ifdef I2C_PTR_POLL_EN
        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            SDAO       <= 1'b0;
            SCLO       <= 1'b1;
            tx_byte    <= {addr, 1'b0};
            bytes_left <= len_q;
            bit_cnt    <= '0;
            addr_phase <= 1'b1;
            state      <= START_A;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
